// File: rtl/ads131_spi_transaction_ctrl_pkg.sv
// ads131_spi_defs: shared definitions for the ADS131A0X SPI transaction controller.
// Contents:
//   state_e            - 3-bit state codes. TRANSACTION_IN_PROGRESS (6) is the value
//                        the SCLK generator decodes to run SCLK.
//   DEFAULT_*          - default frame size and CS setup/hold lengths.
//   last_edge_count()  - CLOCK_CYCLES value of the final SCLK falling edge of a frame.
package ads131_spi_defs;

  typedef enum logic [2:0] {
    ST_IDLE                 = 3'd0,
    ST_CS_SETUP             = 3'd1,
    ST_CS_HOLD              = 3'd2,
    ST_DONE                 = 3'd3,
    TRANSACTION_IN_PROGRESS = 3'd6
  } state_e;

  localparam int unsigned DEFAULT_FRAME_BITS      = 32'd24;
  localparam int unsigned DEFAULT_CS_SETUP_CYCLES = 32'd4;
  localparam int unsigned DEFAULT_CS_HOLD_CYCLES  = 32'd4;

  // A frame has one rising and one falling edge per bit, so the last falling
  // edge is toggle number 2*frame_bits.
  function automatic logic [7:0] last_edge_count(input int unsigned frame_bits);
    return 8'(32'd2 * frame_bits);
  endfunction

endpackage

// File: rtl/ads131_spi_shifter.sv
// ads131_spi_shifter: TX/RX shift registers and SCLK edge-event decode.
// Edge events are derived from changes of CLOCK_CYCLES (toggle count from the SCLK
// generator): an odd new count is a rising edge, an even nonzero one is a falling
// edge. Events lag the real SCLK edge by one system clock.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   load_i           frame accepted: load tx_data_i, clear the receive register
//   tx_data_i        frame to transmit, MSB first
//   xfer_i           controller is in TRANSACTION_IN_PROGRESS
//   clock_cycles_i   SCLK toggle count from the generator
//   sclk_i           SCLK level from the generator
//   miso_i           serial data in
//   mosi_o           serial data out (registered, held between frames)
//   rx_shift_o       receive shift register
//   last_fall_o      falling-edge event of the final bit of the frame
// Build option: ADS131_SPI_LOOPBACK_EN samples the launched MOSI bit instead of MISO.
module ads131_spi_shifter
  import ads131_spi_defs::*;
#(
  parameter int unsigned FRAME_BITS = DEFAULT_FRAME_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [FRAME_BITS-1:0] tx_data_i,
  input  logic                  xfer_i,
  input  logic [7:0]            clock_cycles_i,
  input  logic                  sclk_i,
  input  logic                  miso_i,
  output logic                  mosi_o,
  output logic [FRAME_BITS-1:0] rx_shift_o,
  output logic                  last_fall_o
);

  logic [7:0]            cc_q;
  logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                  mosi_q, mosi_d;
  logic                  edge_s, rise_s, fall_s, sample_s;

`ifdef ADS131_SPI_LOOPBACK_EN
  // The bit launched on the preceding rising edge is still on MOSI at the falling edge.
  assign sample_s = mosi_q;
`else
  assign sample_s = miso_i;
`endif

  // Edge decode and shift-register next state.
  always_comb begin
    edge_s     = xfer_i && (clock_cycles_i != cc_q);
    // The generator half-period is much longer than the event lag, so the SCLK
    // level still matches the edge direction when the event is seen.
    rise_s     = edge_s && clock_cycles_i[0] && sclk_i;
    fall_s     = edge_s && !clock_cycles_i[0] && (clock_cycles_i != 8'd0) && !sclk_i;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    mosi_d     = mosi_q;
    if (load_i) begin
      tx_shift_d = tx_data_i;
      rx_shift_d = '0;
    end else if (rise_s) begin
      mosi_d     = tx_shift_q[FRAME_BITS-1];
      tx_shift_d = FRAME_BITS'({tx_shift_q, 1'b0});
    end else if (fall_s) begin
      rx_shift_d = FRAME_BITS'({rx_shift_q, sample_s});
    end else begin
      tx_shift_d = tx_shift_q;
    end
  end

  // Shift registers, MOSI and the previous toggle count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cc_q       <= 8'd0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      mosi_q     <= 1'b0;
    end else begin
      cc_q       <= clock_cycles_i;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      mosi_q     <= mosi_d;
    end
  end

  assign mosi_o      = mosi_q;
  assign rx_shift_o  = rx_shift_q;
  assign last_fall_o = fall_s && (clock_cycles_i == last_edge_count(FRAME_BITS));

endmodule

// File: rtl/ads131_spi_transaction_ctrl.sv
// ads131_spi_transaction_ctrl: runs one full-duplex SPI mode-1 frame per accepted
// start on the ADS131A0X link, driving the state code that gates an external SCLK
// generator and consuming its SCLK / toggle count.
// Ports:
//   system_clock, reset      clock, asynchronous active-high reset
//   start, tx_data           frame request (accepted only in IDLE) and payload
//   busy                     high in every state except IDLE
//   done, rx_valid           one-cycle pulses at frame completion (DONE state)
//   rx_data                  received frame, updated only with rx_valid
//   state_machine            state code to the SCLK generator
//   SPI_CS, SPI_MOSI         chip select (active low), serial data out
//   SPI_MISO                 serial data in
//   SPI_SCLK, CLOCK_CYCLES   SCLK level and toggle count from the generator
// Build option: ADS131_SPI_LOOPBACK_EN (in ads131_spi_shifter) returns MOSI as rx data.
module ads131_spi_transaction_ctrl
  import ads131_spi_defs::*;
#(
  parameter int unsigned FRAME_BITS      = DEFAULT_FRAME_BITS,
  parameter int unsigned CS_SETUP_CYCLES = DEFAULT_CS_SETUP_CYCLES,
  parameter int unsigned CS_HOLD_CYCLES  = DEFAULT_CS_HOLD_CYCLES
) (
  input  logic                  system_clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic [2:0]            state_machine,
  output logic                  SPI_CS,
  output logic                  SPI_MOSI,
  input  logic                  SPI_MISO,
  input  logic                  SPI_SCLK,
  input  logic [7:0]            CLOCK_CYCLES
);

  // Counters count down to zero, so a phase of N cycles is loaded with N-1.
  localparam logic [15:0] SETUP_LOAD = 16'(CS_SETUP_CYCLES - 32'd1);
  localparam logic [15:0] HOLD_LOAD  = 16'(CS_HOLD_CYCLES - 32'd1);

  state_e                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  cs_q, cs_d;
  logic                  busy_q, done_q, rx_valid_q;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic                  load_s, last_fall_s;
  logic [FRAME_BITS-1:0] rx_shift_s;

  ads131_spi_shifter #(
    .FRAME_BITS(FRAME_BITS)
  ) u_shifter (
    .clk_i          (system_clock),
    .rst_i          (reset),
    .load_i         (load_s),
    .tx_data_i      (tx_data),
    .xfer_i         (state_q == TRANSACTION_IN_PROGRESS),
    .clock_cycles_i (CLOCK_CYCLES),
    .sclk_i         (SPI_SCLK),
    .miso_i         (SPI_MISO),
    .mosi_o         (SPI_MOSI),
    .rx_shift_o     (rx_shift_s),
    .last_fall_o    (last_fall_s)
  );

  // Frame sequencing: next state, phase counter, chip select and captured frame.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cs_d      = cs_q;
    rx_data_d = rx_data_q;
    load_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CS_SETUP;
          cs_d    = 1'b0;
          cnt_d   = SETUP_LOAD;
          load_s  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CS_SETUP: begin
        if (cnt_q == 16'd0) begin
          state_d = TRANSACTION_IN_PROGRESS;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      TRANSACTION_IN_PROGRESS: begin
        if (last_fall_s) begin
          state_d = ST_CS_HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          state_d = TRANSACTION_IN_PROGRESS;
        end
      end
      ST_CS_HOLD: begin
        if (cnt_q == 16'd0) begin
          state_d   = ST_DONE;
          cs_d      = 1'b1;
          // Captured on entry to DONE so rx_data changes together with rx_valid.
          rx_data_d = rx_shift_s;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cs_d    = 1'b1;
      end
    endcase
  end

  // State, counter and registered outputs; flags are computed from the next state.
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      cs_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cs_q       <= cs_d;
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
      rx_valid_q <= (state_d == ST_DONE);
      rx_data_q  <= rx_data_d;
    end
  end

  assign state_machine = state_q;
  assign SPI_CS        = cs_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign rx_valid      = rx_valid_q;
  assign rx_data       = rx_data_q;

endmodule

// File: tb/tb_ads131_spi_transaction_ctrl.sv
// Bench for ads131_spi_transaction_ctrl with an SCLK generator model (half period of
// 7 clocks, runs only in state 6) and a mode-1 slave model. Stimulus pushes expected
// frames into a queue; the monitor pops one on every done pulse and compares.
module tb_ads131_spi_transaction_ctrl;

  localparam int          FB      = 24;
  localparam logic [7:0]  LAST_CC = 8'(2 * FB);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [FB-1:0] tx_data = '0;
  logic          busy, done, rx_valid;
  logic [FB-1:0] rx_data;
  logic [2:0]    sm;
  logic          cs, mosi;
  logic          miso = 1'b0;
  logic          sclk;
  logic [7:0]    cc;
  logic [2:0]    half;

  always #5 clk = ~clk;

  ads131_spi_transaction_ctrl dut (
    .system_clock  (clk),
    .reset         (rst),
    .start         (start),
    .tx_data       (tx_data),
    .busy          (busy),
    .done          (done),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .state_machine (sm),
    .SPI_CS        (cs),
    .SPI_MOSI      (mosi),
    .SPI_MISO      (miso),
    .SPI_SCLK      (sclk),
    .CLOCK_CYCLES  (cc)
  );

  // SCLK generator model: toggles every 7 clocks in state 6, 2*FB toggles max.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk <= 1'b0; cc <= 8'd0; half <= 3'd0;
    end else if (sm != 3'd6) begin
      sclk <= 1'b0; cc <= 8'd0; half <= 3'd0;
    end else if (cc < LAST_CC) begin
      if (half == 3'd6) begin
        half <= 3'd0; sclk <= ~sclk; cc <= cc + 8'd1;
      end else begin
        half <= half + 3'd1;
      end
    end
  end

  typedef struct packed {
    logic [FB-1:0] tx;
    logic [FB-1:0] rx;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  bit end_req = 1'b0;
  int cyc = 0, rise_cnt = 0, setup_cnt = 0, hold_cnt = 0, cs_high_run = 0;
  int sclk_viol = 0, valid_viol = 0, setup_cs_viol = 0, busy_run = 0;
  logic [FB-1:0] mosi_cap = '0, slv_word = '0, slv_sr = '0;
  logic sclk_p = 1'b0, cs_p = 1'b1, rst_p = 1'b0;
  logic [2:0] sm_p = 3'd0;

  function automatic logic [FB-1:0] exp_rx(input logic [FB-1:0] tx, input logic [FB-1:0] sw);
`ifdef ADS131_SPI_LOOPBACK_EN
    return tx;
`else
    return sw;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  endtask

  // Monitor, slave model and scoreboard; all sampling on the falling clock edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst && !rst_p) begin
        chk("rst_cs", 32'(cs), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state", 32'(sm), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
      end
`ifdef ADS131_SPI_LOOPBACK_EN
      miso = 1'bx;
`else
      if (cs) slv_sr = slv_word;
      else if (sclk && !sclk_p) begin
        miso   = slv_sr[FB-1];
        slv_sr = {slv_sr[FB-2:0], 1'b0};
      end
`endif
      if (!cs && cs_p) begin
        n_checks++;
        if (cs_high_run < 2) begin
          n_errors++;
          $display("FAIL cs_gap actual=%0d required>=2", cs_high_run);
        end
        rise_cnt = 0;
        mosi_cap = '0;
      end
      cs_high_run = cs ? cs_high_run + 1 : 0;
      if (sclk && !sclk_p) rise_cnt++;
      if (!sclk && sclk_p) mosi_cap = {mosi_cap[FB-2:0], mosi};
      if (cs && sclk) sclk_viol++;
      if (rx_valid !== done) valid_viol++;
      if (sm == 3'd1) begin
        setup_cnt++;
        if (cs) setup_cs_viol++;
      end
      if (sm == 3'd2) hold_cnt++;
      if (sm == 3'd6 && sm_p == 3'd1) chk("cs_setup_cycles", 32'(setup_cnt), 32'd4);
      if (sm == 3'd3 && sm_p == 3'd2) begin
        chk("cs_hold_cycles", 32'(hold_cnt), 32'd4);
        chk("cs_high_at_done", 32'(cs), 32'd1);
      end
      if (sm == 3'd0) begin
        setup_cnt = 0;
        hold_cnt  = 0;
      end
      if (done) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_done actual=done required=no_frame_pending");
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", 32'(rx_data), 32'(e.rx));
          chk("rx_valid", 32'(rx_valid), 32'd1);
          chk("mosi_bits", 32'(mosi_cap), 32'(e.tx));
          chk("sclk_rises", 32'(rise_cnt), 32'(FB));
        end
      end
      busy_run = busy ? busy_run + 1 : 0;
      if (busy_run == 3000) chk("frame_timeout", 32'(busy_run), 32'd0);
      if (end_req) begin
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("sclk_while_cs_high", 32'(sclk_viol), 32'd0);
        chk("rx_valid_eq_done", 32'(valid_viol), 32'd0);
        chk("cs_low_in_setup", 32'(setup_cs_viol), 32'd0);
        summary();
      end
      if (cyc > 60000) begin
        chk("watchdog", 32'(cyc), 32'd0);
        summary();
      end
      sclk_p = sclk; cs_p = cs; rst_p = rst; sm_p = sm;
    end
  end

  // Raises start for hold negedges; optionally records the expected frame.
  task automatic issue(input logic [FB-1:0] tx, input logic [FB-1:0] sw,
                       input int hold, input bit push);
    tx_data  = tx;
    slv_word = sw;
    if (push) exp_q.push_back('{tx: tx, rx: exp_rx(tx, sw)});
    start = 1'b1;
    repeat (hold) @(negedge clk);
    start   = 1'b0;
    tx_data = ~tx;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) break;
    end
  endtask

  task automatic frame(input logic [FB-1:0] tx, input logic [FB-1:0] sw);
    slv_word = sw;
    @(negedge clk);
    issue(tx, sw, 1, 1'b1);
    wait_done();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    // Basic frames, including all-zero, all-one and the loopback pattern.
    frame(24'hA5C3F0, 24'h123456);
    frame(24'h000000, 24'hFFFFFF);
    frame(24'hFFFFFF, 24'h000000);
    frame(24'h0F0F0F, 24'h800001);
    // start held high for the whole frame: exactly one frame.
    slv_word = 24'h5A5A5A;
    @(negedge clk);
    tx_data = 24'h3C3C3C;
    exp_q.push_back('{tx: 24'h3C3C3C, rx: exp_rx(24'h3C3C3C, 24'h5A5A5A)});
    start = 1'b1;
    wait_done();
    start = 1'b0;
    repeat (30) @(negedge clk);
    // Back-to-back: start raised in the DONE cycle and held into the IDLE cycle.
    slv_word = 24'hC0FFEE;
    @(negedge clk);
    issue(24'h13579B, 24'hC0FFEE, 1, 1'b1);
    wait_done();
    issue(24'hFEDCBA, 24'h2468AC, 2, 1'b1);
    wait_done();
    repeat (3) @(negedge clk);
    // Reset during bit 10: abort without done, then a clean frame.
    slv_word = 24'h777777;
    @(negedge clk);
    issue(24'hABCDEF, 24'h777777, 1, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rise_cnt >= 10) break;
    end
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    frame(24'h0F0F0F, 24'h0A0B0C);
    end_req = 1'b1;
    repeat (5) @(negedge clk);
  end

endmodule
